// File: rtl/io_cmd_seq.sv
// io_cmd_seq: registered host-command decode plus autonomous CIM row-read sequencer (optional IO_CMD_ERR_EN flags orphan buffer selects)
module io_cmd_seq #(
    parameter int AW        = 9,
    parameter int CAW       = 4,
    parameter int READ_ROWS = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wen,
    input  logic          wbuf,
    input  logic          cal,
    input  logic [AW-1:0] a_in,
    input  logic          read_req,
    output logic [AW-1:0] a_out,
    output logic          wrt,
    output logic          wrtbuf,
    output logic          cal_b,
    output logic          read_busy,
    output logic          read_done,
    output logic          err
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] READ = 1'b1;
    logic [0:0]     state_q, state_d;
    logic [CAW-1:0] cnt_q, cnt_d;
    logic [AW-1:0]  a_q, a_d;
    logic           wrt_q, wrt_d, wrtbuf_q, wrtbuf_d, cal_q, cal_d;
    logic           busy_q, busy_d, done_q, done_d;
    logic           start, last;
    assign start = read_req & ~wen & ~cal;
    assign last  = cnt_q == CAW'(READ_ROWS - 1);
    // decode commands in IDLE; in READ sweep rows and ignore every command input
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        wrt_d    = 1'b0;
        wrtbuf_d = 1'b0;
        cal_d    = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;
        if (state_q == IDLE) begin
            wrt_d    = wen & ~wbuf;
            wrtbuf_d = wen & wbuf;
            cal_d    = cal & ~wen & ~wbuf;
            a_d      = start ? '0 : a_in;
            state_d  = start ? READ : IDLE;
            cnt_d    = '0;
            busy_d   = start;
        end else begin
            cnt_d   = last ? '0 : cnt_q + 1'b1;
            a_d     = AW'(cnt_d);
            state_d = last ? IDLE : READ;
            busy_d  = ~last;
            done_d  = last;
        end
    end
    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            wrt_q    <= 1'b0;
            wrtbuf_q <= 1'b0;
            cal_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            wrt_q    <= wrt_d;
            wrtbuf_q <= wrtbuf_d;
            cal_q    <= cal_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end
    assign a_out     = a_q;
    assign wrt       = wrt_q;
    assign wrtbuf    = wrtbuf_q;
    assign cal_b     = cal_q;
    assign read_busy = busy_q;
    assign read_done = done_q;
`ifdef IO_CMD_ERR_EN
    logic err_q;
    // sticky flag for a buffer select without a write in IDLE
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else if (state_q == IDLE && wbuf && !wen) err_q <= 1'b1;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_io_cmd_seq.sv
// tb_io_cmd_seq: directed self-checking bench for io_cmd_seq
module tb_io_cmd_seq;
    logic       clk = 1'b0;
    logic       rst, wen, wbuf, cal, read_req;
    logic [8:0] a_in, a_out;
    logic       wrt, wrtbuf, cal_b, read_busy, read_done, err;
    int         tests = 0;
    int         fails = 0;
    io_cmd_seq dut (
        .clk(clk), .rst(rst), .wen(wen), .wbuf(wbuf), .cal(cal), .a_in(a_in),
        .read_req(read_req), .a_out(a_out), .wrt(wrt), .wrtbuf(wrtbuf),
        .cal_b(cal_b), .read_busy(read_busy), .read_done(read_done), .err(err)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        rst = 1; wen = 1; wbuf = 1; cal = 1; read_req = 1; a_in = 9'h1FF;
        step();
        step();
        tests++;
        if ({a_out, wrt, wrtbuf, cal_b, read_busy, read_done, err} !== 15'd0) begin
            fails++;
            $display("FAIL reset: outputs=%h required 0", {a_out, wrt, wrtbuf, cal_b, read_busy, read_done, err});
        end
        rst = 0; wen = 0; wbuf = 0; cal = 0; read_req = 0; a_in = 0;
        step();
        tests++;
        if (read_busy !== 1'b0 || a_out !== 9'd0) begin
            fails++;
            $display("FAIL reset_idle: busy=%b a_out=%h required 0 0", read_busy, a_out);
        end
    endtask
    task automatic test_decode();
        logic [2:0] v;
        logic [2:0] exp;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {wen, wbuf, cal} = v;
            a_in = 9'h1A5;
            exp = {v[2] & ~v[1], v[2] & v[1], v[0] & ~v[2] & ~v[1]};
            step();
            tests++;
            if ({wrt, wrtbuf, cal_b} !== exp || a_out !== 9'h1A5) begin
                fails++;
                $display("FAIL decode %0d: wrt/wrtbuf/cal_b=%b a_out=%h required %b 1a5", i, {wrt, wrtbuf, cal_b}, a_out, exp);
            end
        end
        {wen, wbuf, cal} = 3'b000;
        a_in = 0;
        step();
    endtask
    task automatic test_read_burst();
        read_req = 1;
        for (int j = 0; j < 16; j++) begin
            if (j == 15) read_req = 0;
            step();
            tests++;
            if (a_out !== 9'(j) || read_busy !== 1'b1 || read_done !== 1'b0) begin
                fails++;
                $display("FAIL burst row %0d: a_out=%h busy=%b done=%b required %h 1 0", j, a_out, read_busy, read_done, 9'(j));
            end
        end
        step();
        tests++;
        if (read_done !== 1'b1 || read_busy !== 1'b0 || a_out !== 9'd0) begin
            fails++;
            $display("FAIL burst_done: done=%b busy=%b a_out=%h required 1 0 0", read_done, read_busy, a_out);
        end
        a_in = 9'h0F0;
        step();
        tests++;
        if (read_done !== 1'b0 || read_busy !== 1'b0 || a_out !== 9'h0F0) begin
            fails++;
            $display("FAIL burst_idle: done=%b busy=%b a_out=%h required 0 0 0f0", read_done, read_busy, a_out);
        end
        a_in = 0;
    endtask
    task automatic test_priority();
        read_req = 1; wen = 1; a_in = 9'h033;
        step();
        tests++;
        if (wrt !== 1'b1 || read_busy !== 1'b0 || a_out !== 9'h033) begin
            fails++;
            $display("FAIL priority: wrt=%b busy=%b a_out=%h required 1 0 033", wrt, read_busy, a_out);
        end
        read_req = 0; wen = 0; a_in = 0;
        step();
    endtask
    task automatic finish_burst(input string name);
        int n;
        n = 0;
        while (read_done !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        tests++;
        if (read_done !== 1'b1) begin
            fails++;
            $display("FAIL %s: read_done=%b required 1 within 20 cycles", name, read_done);
        end
        step();
    endtask
    task automatic test_ignore();
        read_req = 1;
        step();
        read_req = 0; wen = 1; cal = 1; a_in = 9'h1FF;
        for (int j = 1; j < 4; j++) begin
            step();
            tests++;
            if (wrt !== 1'b0 || cal_b !== 1'b0 || a_out !== 9'(j) || read_busy !== 1'b1) begin
                fails++;
                $display("FAIL ignore row %0d: wrt=%b cal_b=%b a_out=%h busy=%b required 0 0 %h 1", j, wrt, cal_b, a_out, read_busy, 9'(j));
            end
        end
        wen = 0; cal = 0; a_in = 0;
        finish_burst("ignore_done");
    endtask
    task automatic test_abort();
        read_req = 1;
        step();
        read_req = 0;
        for (int j = 0; j < 7; j++) step();
        tests++;
        if (a_out !== 9'd7) begin
            fails++;
            $display("FAIL abort_row7: a_out=%h required 007", a_out);
        end
        rst = 1;
        step();
        tests++;
        if (a_out !== 9'd0 || read_busy !== 1'b0 || read_done !== 1'b0) begin
            fails++;
            $display("FAIL abort: a_out=%h busy=%b done=%b required 0 0 0", a_out, read_busy, read_done);
        end
        rst = 0;
        step();
        tests++;
        if (read_done !== 1'b0 || read_busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_nodone: done=%b busy=%b required 0 0", read_done, read_busy);
        end
        read_req = 1;
        step();
        read_req = 0;
        step();
        tests++;
        if (a_out !== 9'd1 || read_busy !== 1'b1) begin
            fails++;
            $display("FAIL abort_restart: a_out=%h busy=%b required 001 1", a_out, read_busy);
        end
        finish_burst("abort_restart_done");
    endtask
    task automatic test_err();
        logic exp;
`ifdef IO_CMD_ERR_EN
        exp = 1'b1;
`else
        exp = 1'b0;
`endif
        rst = 1;
        step();
        rst = 0;
        step();
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL err_init: err=%b required 0", err);
        end
        wbuf = 1;
        step();
        wbuf = 0;
        tests++;
        if (err !== exp || wrtbuf !== 1'b0) begin
            fails++;
            $display("FAIL err_set: err=%b wrtbuf=%b required %b 0", err, wrtbuf, exp);
        end
        step();
        step();
        tests++;
        if (err !== exp) begin
            fails++;
            $display("FAIL err_hold: err=%b required %b", err, exp);
        end
        rst = 1;
        step();
        rst = 0;
        tests++;
        if (err !== 1'b0) begin
            fails++;
            $display("FAIL err_clear: err=%b required 0", err);
        end
    endtask
    initial begin
        test_reset();
        test_decode();
        test_read_burst();
        test_priority();
        test_ignore();
        test_abort();
        test_err();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
